// File: rtl/cpu_ctrl_pkg.sv
// Shared CPU control definitions: sequencer state encoding and default step width.
package cpu_ctrl_pkg;

    localparam int unsigned STEP_WIDTH = 3;

    typedef enum logic [1:0] {
        ST_HALTED  = 2'd0,
        ST_RUNNING = 2'd1,
        ST_SSTEP   = 2'd2
    } seq_state_t;

endpackage : cpu_ctrl_pkg

// File: rtl/step_sequencer_counter.sv
// Micro-step index register: clears to zero on clr, otherwise advances on inc.
module step_counter #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] step
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            step <= '0;
        end else if (clr) begin
            step <= '0;
        end else if (inc) begin
            step <= step + 1'b1;
        end
    end

endmodule : step_counter

// File: rtl/step_sequencer.sv
// T-state sequencer feeding the step decoder: run / halt-at-boundary / single-step
// control with per-instruction terminal step and early step clear.
module step_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = STEP_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             run,
    input  logic             halt,
    input  logic             single_step,
    input  logic             step_clr,
    input  logic [WIDTH-1:0] last_step,
    output logic [WIDTH-1:0] S,
    output logic             EN,
    output logic             instr_done,
    output logic             halted
);

    seq_state_t       state, state_nxt;
    logic             halt_pend, halt_pend_nxt;
    logic [WIDTH-1:0] step;
    logic             wrap;

    step_counter #(.WIDTH(WIDTH)) u_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (EN & ~wrap),
        .clr     (wrap),
        .step    (step)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_HALTED;
            halt_pend <= 1'b0;
        end else begin
            state     <= state_nxt;
            halt_pend <= halt_pend_nxt;
        end
    end

    always_comb begin
        S          = step;
        EN         = (state != ST_HALTED);
        halted     = (state == ST_HALTED);
        wrap       = EN & (step_clr | (step >= last_step));
        instr_done = wrap;

        state_nxt     = state;
        halt_pend_nxt = halt_pend;
        unique case (state)
            ST_HALTED: begin
                if (halt)             state_nxt = ST_HALTED;
                else if (run)         state_nxt = ST_RUNNING;
                else if (single_step) state_nxt = ST_SSTEP;
            end
            ST_RUNNING: begin
                if (halt) halt_pend_nxt = 1'b1;
                // Stop only at an instruction boundary; the wrap already zeroes the step.
                if (wrap && (halt_pend || halt)) begin
                    state_nxt     = ST_HALTED;
                    halt_pend_nxt = 1'b0;
                end
            end
            ST_SSTEP:  state_nxt = ST_HALTED;
            default:   state_nxt = ST_HALTED;
        endcase
    end

endmodule : step_sequencer

// File: tb/tb_step_sequencer.sv
// Scoreboard bench for step_sequencer: a cycle model queues expected outputs as
// stimulus is applied; they are popped and compared at the falling edge.
module tb_step_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       run, halt, single_step, step_clr;
    logic [2:0] last_step;
    logic [2:0] S;
    logic       EN, instr_done, halted;

    step_sequencer #(.WIDTH(3)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .run         (run),
        .halt        (halt),
        .single_step (single_step),
        .step_clr    (step_clr),
        .last_step   (last_step),
        .S           (S),
        .EN          (EN),
        .instr_done  (instr_done),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        int s;
        int en;
        int done;
        int hlt;
    } exp_t;

    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;
    int en_count;

    // reference model state: 0 halted, 1 running, 2 single step
    int m_st, m_step, m_pend;
    int nx_st, nx_step, nx_pend;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_step = 0; m_pend = 0;
    endtask

    task automatic push_expected();
        exp_t e;
        int   active, w;
        active = (m_st != 0) ? 1 : 0;
        w      = (active != 0 && (step_clr === 1'b1 || m_step >= int'(last_step))) ? 1 : 0;
        e.s = m_step; e.en = active; e.done = w; e.hlt = 1 - active;
        sb.push_back(e);
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 0, 1);
            return;
        end
        e = sb.pop_front();
        check({tag, "_S"},    int'(S),          e.s);
        check({tag, "_EN"},   int'(EN),         e.en);
        check({tag, "_done"}, int'(instr_done), e.done);
        check({tag, "_halt"}, int'(halted),     e.hlt);
    endtask

    task automatic model_next();
        int active, w;
        active  = (m_st != 0) ? 1 : 0;
        w       = (active != 0 && (step_clr === 1'b1 || m_step >= int'(last_step))) ? 1 : 0;
        nx_st   = m_st;
        nx_pend = m_pend;
        nx_step = m_step;
        if (active != 0) nx_step = (w != 0) ? 0 : ((m_step + 1) % 8);
        if (m_st == 0) begin
            if (halt)             nx_st = 0;
            else if (run)         nx_st = 1;
            else if (single_step) nx_st = 2;
        end else if (m_st == 1) begin
            if (w != 0 && (m_pend != 0 || halt)) begin
                nx_st = 0; nx_pend = 0;
            end else if (halt) begin
                nx_pend = 1;
            end
        end else begin
            nx_st = 0;
        end
    endtask

    // Entered 1 time unit after a rising edge; leaves at the same point of the next cycle.
    task automatic cyc(input string tag, input logic r, input logic h, input logic ss,
                       input logic clr, input logic [2:0] last);
        run = r; halt = h; single_step = ss; step_clr = clr; last_step = last;
        push_expected();
        @(negedge clk);
        if (EN) en_count++;
        pop_compare(tag);
        model_next();
        @(posedge clk);
        #1;
        m_st = nx_st; m_step = nx_step; m_pend = nx_pend;
    endtask

    initial begin
        reset_n = 1'b0;
        run = 0; halt = 0; single_step = 0; step_clr = 0; last_step = 3'd0;
        en_count = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // idle after reset
        for (int i = 0; i < 10; i++) cyc("idle", 0, 0, 0, 0, 3'd0);

        // free run with last_step=5
        cyc("run5_start", 1, 0, 0, 0, 3'd5);
        for (int i = 0; i < 14; i++) cyc("run5", 0, 0, 0, 0, 3'd5);

        // early clear at S=2 with last_step=7
        for (int i = 0; i < 10 && m_step != 2; i++) cyc("clr_seek", 0, 0, 0, 0, 3'd7);
        check("clr_at_S2", int'(S), 2);
        cyc("clr", 0, 0, 0, 1, 3'd7);
        check("clr_S_after", int'(S), 0);
        for (int i = 0; i < 3; i++) cyc("clr_post", 0, 0, 0, 0, 3'd7);

        // clr together with step==last, then last_step lowered below the current step
        for (int i = 0; i < 10 && m_step != 4; i++) cyc("clr_eq_seek", 0, 0, 0, 0, 3'd4);
        cyc("clr_eq", 0, 0, 0, 1, 3'd4);
        for (int i = 0; i < 10 && m_step != 5; i++) cyc("lower_seek", 0, 0, 0, 0, 3'd7);
        cyc("lower", 0, 0, 0, 0, 3'd2);
        check("lower_wrapped", int'(S), 0);
        for (int i = 0; i < 9; i++) cyc("full8", 0, 0, 0, 0, 3'd7);

        // halt pulse at S=1, last_step=3
        for (int i = 0; i < 10 && m_step != 1; i++) cyc("halt_seek", 0, 0, 0, 0, 3'd3);
        cyc("halt_pulse", 0, 1, 0, 0, 3'd3);
        cyc("halt_S2", 0, 0, 0, 0, 3'd3);
        cyc("halt_S3", 0, 0, 0, 0, 3'd3);
        check("halt_done", int'(halted), 1);
        for (int i = 0; i < 3; i++) cyc("halt_idle", 0, 0, 0, 0, 3'd3);
        cyc("halt_prio", 1, 1, 0, 0, 3'd3);
        cyc("resume", 1, 0, 0, 0, 3'd3);
        for (int i = 0; i < 5; i++) cyc("resumed", 0, 0, 0, 0, 3'd3);

        // halt level until stopped
        for (int i = 0; i < 10 && m_st != 0; i++) cyc("halt_lvl", 0, 1, 0, 0, 3'd3);
        cyc("halt_rel", 0, 0, 0, 0, 3'd2);

        // three single-step pulses, 4 cycles apart
        en_count = 0;
        for (int p = 0; p < 3; p++) begin
            cyc("ss_pulse", 0, 0, 1, 0, 3'd2);
            for (int i = 0; i < 3; i++) cyc("ss_gap", 0, 0, 0, 0, 3'd2);
        end
        check("ss_en_count", en_count, 3);
        check("ss_S_final", int'(S), 0);

        // single_step held high: one step every other cycle
        en_count = 0;
        for (int i = 0; i < 6; i++) cyc("ss_hold", 0, 0, 1, 0, 3'd7);
        cyc("ss_hold_end", 0, 0, 0, 0, 3'd7);
        check("ss_hold_count", en_count, 3);

        // asynchronous reset mid-cycle at S=4
        cyc("rst_go", 1, 0, 0, 0, 3'd7);
        for (int i = 0; i < 10 && m_step != 4; i++) cyc("rst_seek", 0, 0, 0, 0, 3'd7);
        run = 0; halt = 0; single_step = 0; step_clr = 0;
        push_expected();
        @(negedge clk);
        pop_compare("rst_pre");
        #2 reset_n = 1'b0;
        model_reset();
        push_expected();
        #1 pop_compare("rst_async");
        @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 4; i++) cyc("rst_idle", 0, 0, 0, 0, 3'd7);
        cyc("rst_run", 1, 0, 0, 0, 3'd7);
        for (int i = 0; i < 3; i++) cyc("rst_resumed", 0, 0, 0, 0, 3'd7);

        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

endmodule : tb_step_sequencer
